bitwise_reduce_acc: RTL and testbench

Streaming, parametrised successor to the combinational reduction-AND cell. It folds a frame of `len` input words into one WIDTH-bit result using a selectable bitwise operator (AND/OR/XOR), with valid/ready handshakes on input and output. It also reports the all-ones and any-one reductions of the result. It sits between a word producer and any consumer that needs per-frame bitwise summaries, such as mask merging, parity or all-set detection.

---
 rtl/bitwise_reduce_acc_if.sv | 28 ++
 rtl/bitwise_reduce_acc.sv | 91 +++++++++
 tb/tb_bitwise_reduce_acc.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/bitwise_reduce_acc_if.sv
// rtl/bitwise_reduce_acc_if.sv - frame control, input stream and result stream of the bitwise reducer
interface bitwise_reduce_acc_if #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 4
);
  logic             start;
  logic [1:0]       mode;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_all;
  logic             out_any;
  logic             out_ready;
  logic             busy;

  modport master (
    output start, mode, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_all, out_any, busy
  );

  modport slave (
    input  start, mode, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_all, out_any, busy
  );
endinterface

// File: rtl/bitwise_reduce_acc.sv
// rtl/bitwise_reduce_acc.sv - folds a frame of len words into one word with AND/OR/XOR
module bitwise_reduce_acc #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bitwise_reduce_acc_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       mode_q, mode_nxt;
  logic [CNT_W-1:0] len_q, len_nxt;
  logic [WIDTH-1:0] identity;
  logic [WIDTH-1:0] folded;
  logic             xfer;

  // OR and XOR start from zero; AND and the reserved code start from all-ones
  always_comb begin
    identity = '1;
    if (bus.mode == 2'b01 || bus.mode == 2'b10) identity = '0;
  end

  always_comb begin
    folded = acc & bus.in_data;
    case (mode_q)
      2'b01:   folded = acc | bus.in_data;
      2'b10:   folded = acc ^ bus.in_data;
      default: folded = acc & bus.in_data;
    endcase
  end

  assign xfer = (state == ACC) && bus.in_valid;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    mode_nxt  = mode_q;
    len_nxt   = len_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          mode_nxt = bus.mode;
          len_nxt  = bus.len;
          acc_nxt  = identity;
          cnt_nxt  = '0;
          state_nxt = (bus.len == '0) ? DONE : ACC;
        end
      end
      ACC: begin
        if (xfer) begin
          acc_nxt = folded;
          cnt_nxt = cnt + CNT_W'(1);
          // terminal compare ends the frame before cnt could ever wrap
          if (cnt == len_q - CNT_W'(1)) state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      mode_q <= 2'b00;
      len_q  <= '0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
      mode_q <= mode_nxt;
      len_q  <= len_nxt;
    end
  end

  assign bus.in_ready  = (state == ACC);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_data  = acc;
  assign bus.out_all   = &acc;
  assign bus.out_any   = |acc;
endmodule

// File: tb/tb_bitwise_reduce_acc.sv
// tb/tb_bitwise_reduce_acc.sv - randomized and directed checks of bitwise_reduce_acc against a fold model
module tb_bitwise_reduce_acc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [4:0] frame_words [16];

  bitwise_reduce_acc_if #(.WIDTH(5), .CNT_W(4)) bus ();

  bitwise_reduce_acc #(.WIDTH(5), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] ref_fold(input logic [1:0] m, input int l);
    logic [4:0] r;
    r = (m == 2'b01 || m == 2'b10) ? 5'b00000 : 5'b11111;
    for (int i = 0; i < l; i++) begin
      if (m == 2'b01)      r = r | frame_words[i];
      else if (m == 2'b10) r = r ^ frame_words[i];
      else                 r = r & frame_words[i];
    end
    return r;
  endfunction

  task automatic check_zero_outputs(input string tag);
    check({tag, ".busy"},      bus.busy,      0);
    check({tag, ".in_ready"},  bus.in_ready,  0);
    check({tag, ".out_valid"}, bus.out_valid, 0);
    check({tag, ".out_data"},  bus.out_data,  0);
    check({tag, ".out_all"},   bus.out_all,   0);
    check({tag, ".out_any"},   bus.out_any,   0);
  endtask

  // gap < 0 picks a random 0..2 idle cycles before each word; otherwise a fixed gap
  task automatic run_frame(input string tag, input logic [1:0] m, input int l, input int gap, input int hold);
    logic [4:0] exp;
    logic [4:0] held;
    int g;
    exp = ref_fold(m, l);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.len   = 4'(l);
    tick();
    bus.start = 1'b0;
    check({tag, ".busy_after_start"}, bus.busy, 1);
    check({tag, ".in_ready_after_start"}, bus.in_ready, (l != 0));
    check({tag, ".out_valid_after_start"}, bus.out_valid, (l == 0));
    for (int i = 0; i < l; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      for (int k = 0; k < g; k++) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 5'($urandom);
        bus.start    = 1'($urandom);
        bus.mode     = 2'($urandom);
        bus.len      = 4'($urandom);
        tick();
        check({tag, ".gap_out_valid"}, bus.out_valid, 0);
      end
      bus.start    = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = frame_words[i];
      check({tag, ".in_ready_word"}, bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      check({tag, ".out_valid_after_word"}, bus.out_valid, (i == l - 1));
    end
    for (int k = 0; k < hold; k++) begin
      held = bus.out_data;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 5'($urandom);
      bus.start     = 1'($urandom);
      tick();
      check({tag, ".hold_data"},  bus.out_data,  held);
      check({tag, ".hold_ready"}, bus.in_ready,  0);
      check({tag, ".hold_valid"}, bus.out_valid, 1);
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    check({tag, ".out_data"}, bus.out_data, exp);
    check({tag, ".out_all"},  bus.out_all,  (exp == 5'b11111));
    check({tag, ".out_any"},  bus.out_any,  (exp != 5'b00000));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, ".idle_valid"}, bus.out_valid, 0);
    check({tag, ".idle_busy"},  bus.busy,      0);
    check({tag, ".acc_kept"},   bus.out_data,  exp);
  endtask

  initial begin
    bus.start = 1'b0; bus.mode = 2'b00; bus.len = 4'd0;
    bus.in_valid = 1'b0; bus.in_data = 5'd0; bus.out_ready = 1'b0;
    #12;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    tick();

    frame_words[0] = 5'b11111; frame_words[1] = 5'b11110;
    run_frame("and2", 2'b00, 2, 0, 0);
    frame_words[0] = 5'b11111;
    run_frame("and1", 2'b00, 1, 0, 0);
    frame_words[0] = 5'b00001; frame_words[1] = 5'b00011; frame_words[2] = 5'b00111;
    run_frame("xor3gap", 2'b10, 3, 2, 0);
    run_frame("empty_and", 2'b00, 0, 0, 0);
    run_frame("empty_or", 2'b01, 0, 0, 0);
    frame_words[0] = 5'b10110; frame_words[1] = 5'b00101;
    run_frame("or_bp", 2'b01, 2, 0, 3);

    // abort a frame after one word with an asynchronous reset between edges
    bus.start = 1'b1; bus.mode = 2'b00; bus.len = 4'd3;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 5'b01101;
    tick();
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    #3;
    rst_n = 1'b1;
    tick();
    check_zero_outputs("after_reset");
    frame_words[0] = 5'b10101;
    run_frame("and_post", 2'b00, 1, 0, 0);

    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < 16; i++) frame_words[i] = 5'($urandom);
      run_frame("rand", 2'($urandom), int'($urandom_range(0, 15)), -1, int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
